// File: rtl/seg_scan_pkg.sv
// Shared constants, scan state encoding and digit helpers
// for the multiplexed display scanner.
package seg_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int BUS_W      = NUM_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // True when digit idx (never 0) is a leading zero:
   // it and every digit above it are zero.
   function automatic logic lead_zero(
      input logic [BUS_W-1:0] d,
      input logic [IDX_W-1:0] idx
   );
      logic z;
      z = (idx != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(idx) &&
             d[k*DIGIT_W +: DIGIT_W] != '0)
            z = 1'b0;
      end
      return z;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Shared dwell counter for the scanner; the limit is
// selected per state and terminal count is reported.
module scan_timer
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic clear,
   input  logic sel_drive,
   output logic term
);

   localparam int MAX_LIM =
      (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CNT_W =
      (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lim;

   assign lim = sel_drive ? CNT_W'(CLK_DIV - 1)
                          : CNT_W'(BLANK_CYCLES - 1);
   assign term = (cnt == lim);

   // Count up to the active limit, then restart at zero
   always_ff @(posedge sys_clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (term)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan controller: IDLE/BLANK/DRIVE.
// Optional macro: LEADING_ZERO_BLANK_EN.
module digit_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [BUS_W-1:0]      digits_in,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic                  cfg_anode_active_low,
   output logic [DIGIT_W-1:0]    hex_out,
   output logic                  digit_valid,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic                  dp_out,
   output logic                  frame_done
);

   localparam logic [IDX_W-1:0] LAST_IDX =
      IDX_W'(NUM_DIGITS - 1);

   scan_state_t           state;
   logic [IDX_W-1:0]      idx;
   logic [BUS_W-1:0]      snap_dig;
   logic [NUM_DIGITS-1:0] snap_dp;
   logic                  tmr_clear;
   logic                  tmr_term;

   logic                  show;
   logic [NUM_DIGITS-1:0] an_inact;
   logic [NUM_DIGITS-1:0] an_drive;
   logic [DIGIT_W-1:0]    hex_cur;
   logic                  dp_cur;

   assign tmr_clear = (state == ST_IDLE) || !enable;

   scan_timer #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .clear     (tmr_clear),
      .sel_drive (state == ST_DRIVE),
      .term      (tmr_term)
   );

   // Drive values for the current index from the snapshot
   always_comb begin
      show = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      show = !lead_zero(snap_dig, idx);
`endif
      an_inact = {NUM_DIGITS{cfg_anode_active_low}};
      an_drive = show ? (NUM_DIGITS'(1) << idx)
                      : '0;
      an_drive = an_drive ^ an_inact;
      hex_cur  = snap_dig[idx*DIGIT_W +: DIGIT_W];
      dp_cur   = snap_dp[idx] & show;
   end

   // Scan FSM with registered display outputs
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         snap_dig    <= '0;
         snap_dp     <= '0;
         hex_out     <= '0;
         digit_valid <= 1'b0;
         dp_out      <= 1'b0;
         frame_done  <= 1'b0;
         an_out      <= an_inact;
      end else begin
         frame_done <= 1'b0;
         if (!enable) begin
            state       <= ST_IDLE;
            idx         <= '0;
            hex_out     <= '0;
            digit_valid <= 1'b0;
            dp_out      <= 1'b0;
            an_out      <= an_inact;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state       <= ST_BLANK;
                  idx         <= '0;
                  snap_dig    <= digits_in;
                  snap_dp     <= dp_in;
                  hex_out     <= '0;
                  digit_valid <= 1'b0;
                  dp_out      <= 1'b0;
                  an_out      <= an_inact;
               end
               ST_BLANK: begin
                  if (tmr_term) begin
                     state       <= ST_DRIVE;
                     hex_out     <= hex_cur;
                     digit_valid <= show;
                     dp_out      <= dp_cur;
                     an_out      <= an_drive;
                  end else begin
                     hex_out     <= '0;
                     digit_valid <= 1'b0;
                     dp_out      <= 1'b0;
                     an_out      <= an_inact;
                  end
               end
               ST_DRIVE: begin
                  if (tmr_term) begin
                     state       <= ST_BLANK;
                     idx         <= idx + IDX_W'(1);
                     hex_out     <= '0;
                     digit_valid <= 1'b0;
                     dp_out      <= 1'b0;
                     an_out      <= an_inact;
                     if (idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        snap_dig   <= digits_in;
                        snap_dp    <= dp_in;
                     end
                  end else begin
                     hex_out     <= hex_cur;
                     digit_valid <= show;
                     dp_out      <= dp_cur;
                     an_out      <= an_drive;
                  end
               end
               default: begin
                  state       <= ST_IDLE;
                  idx         <= '0;
                  hex_out     <= '0;
                  digit_valid <= 1'b0;
                  dp_out      <= 1'b0;
                  an_out      <= an_inact;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with
// CLK_DIV=4, BLANK_CYCLES=2.
module tb_digit_scan_ctrl;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        cfg_anode_active_low;
   logic [3:0]  hex_out;
   logic        digit_valid;
   logic [3:0]  an_out;
   logic        dp_out;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic       v;
      logic [3:0] hex;
      logic       dp;
      logic       fd;
   } vec_t;

   vec_t tbl[$];

   digit_scan_ctrl #(
      .CLK_DIV      (4),
      .BLANK_CYCLES (2)
   ) dut (
      .sys_clk              (sys_clk),
      .reset                (reset),
      .enable               (enable),
      .digits_in            (digits_in),
      .dp_in                (dp_in),
      .cfg_anode_active_low (cfg_anode_active_low),
      .hex_out              (hex_out),
      .digit_valid          (digit_valid),
      .an_out               (an_out),
      .dp_out               (dp_out),
      .frame_done           (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic vec_t mkv(
      int c, logic [3:0] a, logic v,
      logic [3:0] h, logic d, logic f);
      vec_t r;
      r.cyc = c; r.an = a; r.v = v;
      r.hex = h; r.dp = d; r.fd = f;
      return r;
   endfunction

   task automatic chk(string name,
                      logic [15:0] act,
                      logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic goto(int n);
      while (cyc < n) tick();
   endtask

   task automatic chk_all(string tag, vec_t e);
      chk({tag, " an_out"}, 16'(an_out), 16'(e.an));
      chk({tag, " digit_valid"}, 16'(digit_valid), 16'(e.v));
      chk({tag, " hex_out"}, 16'(hex_out), 16'(e.hex));
      chk({tag, " dp_out"}, 16'(dp_out), 16'(e.dp));
      chk({tag, " frame_done"}, 16'(frame_done), 16'(e.fd));
   endtask

   // Reset, then release with enable high; the next edge
   // is cycle 1 (IDLE -> BLANK).
   task automatic start_run(logic [15:0] d,
                            logic [3:0] p,
                            logic cfg);
      reset                = 1'b1;
      enable               = 1'b1;
      digits_in            = d;
      dp_in                = p;
      cfg_anode_active_low = cfg;
      tick();
      tick();
      reset  = 1'b0;
      cyc    = 0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      digits_in = '0;
      dp_in = '0;
      cfg_anode_active_low = 1'b0;

      // Main frame sequence, digits 1234, dp on digits 0 and 2
      tbl.push_back(mkv( 1, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv( 2, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv( 3, 4'b0001, 1, 4'h4, 1, 0));
      tbl.push_back(mkv( 6, 4'b0001, 1, 4'h4, 1, 0));
      tbl.push_back(mkv( 7, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv( 8, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv( 9, 4'b0010, 1, 4'h3, 0, 0));
      tbl.push_back(mkv(12, 4'b0010, 1, 4'h3, 0, 0));
      tbl.push_back(mkv(13, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv(15, 4'b0100, 1, 4'h2, 1, 0));
      tbl.push_back(mkv(18, 4'b0100, 1, 4'h2, 1, 0));
      tbl.push_back(mkv(21, 4'b1000, 1, 4'h1, 0, 0));
      tbl.push_back(mkv(24, 4'b1000, 1, 4'h1, 0, 0));
      tbl.push_back(mkv(25, 4'b0000, 0, 4'h0, 0, 1));
      tbl.push_back(mkv(26, 4'b0000, 0, 4'h0, 0, 0));
      tbl.push_back(mkv(27, 4'b0001, 1, 4'h4, 1, 0));

      start_run(16'h1234, 4'b0101, 1'b0);
      // state while reset held, cfg=0
      chk_all("reset", mkv(0, 4'b0000, 0, 4'h0, 0, 0));
      foreach (tbl[i]) begin
         goto(tbl[i].cyc);
         chk_all($sformatf("vec%0d", i), tbl[i]);
      end

      // Snapshot holds mid-frame; new value next frame
      start_run(16'h1234, 4'b0000, 1'b0);
      goto(10);
      digits_in = 16'h5678;
      goto(15); chk("snap d2", 16'(hex_out), 16'h2);
      goto(21); chk("snap d3", 16'(hex_out), 16'h1);
      goto(25); chk("snap fd", 16'(frame_done), 16'h1);
      goto(27); chk("snap f2d0", 16'(hex_out), 16'h8);
      goto(33); chk("snap f2d1", 16'(hex_out), 16'h7);
      goto(39); chk("snap f2d2", 16'(hex_out), 16'h6);
      goto(45); chk("snap f2d3", 16'(hex_out), 16'h5);
      chk("snap f2an3", 16'(an_out), 16'b1000);

      // Active-low anodes
      start_run(16'h1234, 4'b0000, 1'b1);
      chk("al reset an", 16'(an_out), 16'b1111);
      goto(1); chk("al blank an", 16'(an_out), 16'b1111);
      goto(3); chk("al d0 an", 16'(an_out), 16'b1110);
      goto(9); chk("al d1 an", 16'(an_out), 16'b1101);

      // Enable dropped mid-DRIVE of digit 2
      start_run(16'h1234, 4'b0000, 1'b0);
      goto(16);
      chk("en pre an", 16'(an_out), 16'b0100);
      enable = 1'b0;
      tick();
      chk("en off an", 16'(an_out), 16'b0000);
      chk("en off v", 16'(digit_valid), 16'h0);
      tick();
      enable = 1'b1;
      cyc = 0;
      goto(2);
      chk("en re blank", 16'(an_out), 16'b0000);
      goto(3);
      chk("en re an", 16'(an_out), 16'b0001);
      chk("en re hex", 16'(hex_out), 16'h4);

      // Reset mid-DRIVE of digit 3: no frame_done
      start_run(16'h1234, 4'b0000, 1'b0);
      goto(22);
      chk("rst pre an", 16'(an_out), 16'b1000);
      reset = 1'b1;
      tick();
      chk("rst an", 16'(an_out), 16'b0000);
      chk("rst v", 16'(digit_valid), 16'h0);
      chk("rst hex", 16'(hex_out), 16'h0);
      for (int k = 0; k < 4; k++) begin
         chk("rst fd", 16'(frame_done), 16'h0);
         tick();
      end
      reset = 1'b0;

      // Leading zeros, digits 0070
      start_run(16'h0070, 4'b0000, 1'b0);
      goto(3);
      chk("lz d0 an", 16'(an_out), 16'b0001);
      chk("lz d0 hex", 16'(hex_out), 16'h0);
      chk("lz d0 v", 16'(digit_valid), 16'h1);
      goto(9);
      chk("lz d1 an", 16'(an_out), 16'b0010);
      chk("lz d1 hex", 16'(hex_out), 16'h7);
`ifdef LEADING_ZERO_BLANK_EN
      goto(15);
      chk("lz d2 an", 16'(an_out), 16'b0000);
      chk("lz d2 v", 16'(digit_valid), 16'h0);
      goto(21);
      chk("lz d3 an", 16'(an_out), 16'b0000);
      chk("lz d3 v", 16'(digit_valid), 16'h0);
`else
      goto(15);
      chk("lz d2 an", 16'(an_out), 16'b0100);
      chk("lz d2 v", 16'(digit_valid), 16'h1);
      goto(21);
      chk("lz d3 an", 16'(an_out), 16'b1000);
      chk("lz d3 v", 16'(digit_valid), 16'h1);
`endif
      goto(24);
      chk("lz fd early", 16'(frame_done), 16'h0);
      goto(25);
      chk("lz fd", 16'(frame_done), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
